mips_muldiv_unit: RTL



---
 rtl/mips_muldiv_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide on operand magnitudes; signs are applied in a final fix-up cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_bZero;
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_opB;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divTrial;
    logic               w_divOk;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_magA = (op[0] && a[WIDTH-1]) ? -a : a;
        w_magB = (op[0] && b[WIDTH-1]) ? -b : b;
    end

    // upper/lower hold {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_mulSum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opB} : {(WIDTH+1){1'b0}});
        w_divShift = {r_upper, r_lower[WIDTH-1]};
        w_divTrial = w_divShift - {1'b0, r_opB};
        w_divOk    = ~w_divTrial[WIDTH];
    end

    always_comb begin
        w_prod       = {r_upper, r_lower};
        w_prodSigned = r_negRes ? -w_prod : w_prod;
        w_quo        = r_bZero ? {WIDTH{1'b1}} : (r_negRes ? -r_lower : r_lower);
        w_rem        = r_negRem ? -r_upper : r_upper;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_isDiv  <= 1'b0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_bZero  <= 1'b0;
            r_upper  <= '0;
            r_lower  <= '0;
            r_opB    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !op[2]) begin
                        r_upper  <= '0;
                        r_lower  <= w_magA;
                        r_opB    <= w_magB;
                        r_isDiv  <= op[1];
                        r_negRes <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_negRem <= op[0] & a[WIDTH-1];
                        r_bZero  <= (b == '0);
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else if (start && !op[1]) begin
                        if (op[0]) begin
                            r_lo <= a;
                        end else begin
                            r_hi <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (r_isDiv) begin
                        r_upper <= w_divOk ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
                        r_lower <= {r_lower[WIDTH-2:0], w_divOk};
                    end else begin
                        r_upper <= w_mulSum[WIDTH:1];
                        r_lower <= {w_mulSum[0], r_lower[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prodSigned[2*WIDTH-1:WIDTH];
                        r_lo <= w_prodSigned[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_dz    <= r_isDiv & r_bZero;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
